// File: rtl/dmem_access_unit_if.sv
// Request/grant/response bus between the memory-stage access unit and the data memory.
interface dmem_access_unit_if #(
    parameter int unsigned N = 64
) ();
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [N-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// LEGv8 memory-stage load/store unit: drives a multi-cycle data memory and stalls the pipeline.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject accesses not aligned to 8 bytes.
module dmem_access_unit #(
    parameter int unsigned N       = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemRead_M,
    input  logic                MemWrite_M,
    input  logic [N-1:0]        aluResult_M,
    input  logic [N-1:0]        writeData_M,
    dmem_access_unit_if.master  mem,
    output logic                stall_M,
    output logic [N-1:0]        readData_M,
    output logic                done_M,
    output logic                bus_err_M,
    output logic                align_err_M
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

    state_e       state_q, state_d;
    logic         req_q, req_d;
    logic         we_q, we_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] rdata_q, rdata_d;
    logic         done_q, done_d;
    logic         bus_err_q, bus_err_d;
    logic         align_err_q, align_err_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  cnt_inc;
    logic         mem_op;
    logic         misaligned;

    assign mem_op = MemRead_M | MemWrite_M;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (aluResult_M[2:0] != 3'b000);
`else
    assign misaligned = 1'b0;
`endif

    // Saturating so a huge TIMEOUT can never wrap the counter back to zero.
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        bus_err_d   = 1'b0;
        align_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (mem_op) begin
                    addr_d  = aluResult_M;
                    wdata_d = writeData_M;
                    we_d    = MemWrite_M;
                    if (misaligned) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        align_err_d = 1'b1;
                        if (!MemWrite_M) rdata_d = '0;
                    end else begin
                        state_d = StReq;
                        req_d   = 1'b1;
                    end
                end
            end
            StReq: begin
                if (mem.mem_gnt) begin
                    state_d = StWait;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (mem.mem_rvalid) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    if (!we_q) rdata_d = mem.mem_rdata;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TimeoutVal) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        bus_err_d = 1'b1;
                        if (!we_q) rdata_d = '0;
                    end
                end
            end
            StDone: begin
                // The finishing instruction is still on the inputs; do not re-accept it.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            bus_err_q   <= bus_err_d;
            align_err_q <= align_err_d;
        end
    end

    // Reset gates the IDLE term so stall drops at once even while an op is still presented.
    assign stall_M = ~reset & (((state_q == StIdle) & mem_op) |
                               (state_q == StReq) | (state_q == StWait));

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign readData_M    = rdata_q;
    assign done_M        = done_q;
    assign bus_err_M     = bus_err_q;
    assign align_err_M   = align_err_q;

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage load/store unit for the pipelined LEGv8 core. Takes the address (ALU result) and store data produced by the execute stage and carries them out over a request/grant/response handshake to a multi-cycle data memory. It stalls the pipeline until the access completes, and returns registered load data and error flags to writeback.

## Interface
Parameters:
- N, 64, data/address width
- TIMEOUT, 255, maximum cycles spent in WAIT before a bus error (range 1..2^16-1)

Ports:
- clk  input  1  core clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- MemRead_M  input  1  load request from the EX/MEM register
- MemWrite_M  input  1  store request from the EX/MEM register
- aluResult_M  input  N  byte address
- writeData_M  input  N  store data
- mem_gnt  input  1  memory accepted the request
- mem_rvalid  input  1  response valid (load data or store ack)
- mem_rdata  input  N  load data from memory
- mem_req  output  1  request valid
- mem_we  output  1  1 = store, 0 = load
- mem_addr  output  N  latched address
- mem_wdata  output  N  latched store data
- stall_M  output  1  hold IF..MEM pipeline registers
- readData_M  output  N  registered load data
- done_M  output  1  one-cycle completion pulse
- bus_err_M  output  1  timeout on this access (pulse with done_M)
- align_err_M  output  1  misaligned access (pulse with done_M)

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - When MemRead_M or MemWrite_M is high: latch aluResult_M, writeData_M and the direction (MemWrite_M has priority when both are high), then go to REQ.
  - A misaligned address goes to DONE with the align flag set instead; see Configuration.
  - Otherwise stay in IDLE.
- REQ: mem_req=1 with the latched mem_addr, mem_wdata and mem_we held stable. When mem_gnt=1, go to WAIT and clear the timeout counter.
- WAIT: mem_req=0.
  - On mem_rvalid: go to DONE, capturing mem_rdata into readData_M for loads only.
  - Otherwise increment the counter; when it reaches TIMEOUT, go to DONE with the bus error set and readData_M=0 for loads.
- DONE: done_M=1 and the error flags are valid. The MemRead_M/MemWrite_M inputs are ignored because the same instruction is still present. Go to IDLE.
- Stores leave readData_M unchanged. readData_M holds its last value between loads.
- stall_M = (IDLE and (MemRead_M or MemWrite_M)) or REQ or WAIT. stall_M is 0 in DONE, so the pipeline advances exactly once per access.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.

## Timing
- Reset (asynchronous): state=IDLE; mem_req, mem_we, stall_M, done_M, bus_err_M, align_err_M = 0; mem_addr, mem_wdata, readData_M = 0. mem_req drops immediately on reset assertion, and the in-flight access is abandoned.
- Minimum access (mem_gnt in the first REQ cycle, mem_rvalid one cycle later): op presented at cycle 0 (IDLE, stall), REQ at cycle 1, WAIT at cycle 2, DONE at cycle 3. That is 3 stall cycles; readData_M is valid from cycle 3 on.
- Each extra cycle of mem_gnt or mem_rvalid delay adds one stall cycle.
- Back-to-back memory ops: the next op is accepted in the IDLE cycle following DONE.
- The counter is 16 bits wide and saturates; it never wraps.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - In IDLE, a request with aluResult_M[2:0] != 0 issues no memory request.
  - The FSM goes IDLE -> DONE, with stall_M=1 for that one IDLE cycle.
  - In DONE, align_err_M=1 and done_M=1; for loads, readData_M=0.
- DMEM_ALIGN_CHECK_EN undefined: no alignment check. Every address is passed through unchanged and align_err_M is tied to 0.

## Test plan
- Load, gnt at the first REQ, rvalid 1 cycle later with mem_rdata=64'hDEADBEEF_00000001, address 0x40 -> mem_req for 1 cycle, mem_we=0, stall_M high for 3 cycles, done_M at cycle 3, readData_M=64'hDEADBEEF_00000001.
- Store of 0x1234 to 0x80 with gnt delayed 2 cycles -> mem_we=1, mem_wdata=0x1234 held through REQ, stall_M high for 5 cycles, readData_M unchanged.
- MemRead_M=MemWrite_M=1 -> a store is issued (mem_we=1).
- Load with TIMEOUT=4 and rvalid never asserted -> bus_err_M and done_M pulse after 4 WAIT cycles, readData_M=0, FSM returns to IDLE.
- Reset asserted in WAIT -> mem_req, stall_M and readData_M go to 0 with no clock edge; a later mem_rvalid is ignored.
- With DMEM_ALIGN_CHECK_EN, a load at 0x43 -> no mem_req, 1 stall cycle, align_err_M=1 with done_M. Without the macro -> a normal access to 0x43.
